psr_cond_unit: RTL and testbench

- Consumer end of the ALU flag interface.
- Captures the 5-bit ALU Flags vector into the processor status register (PSR), using opcode-dependent update masks.
- Resolves branch/jump/Scond condition codes against the PSR through a request/valid handshake.
- Holds one shadow PSR copy for interrupt save/restore. Sits between the ALU and the fetch/branch control FSM.

---
 rtl/psr_cond_unit.sv | 147 ++++++++++++++
 tb/tb_psr_cond_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/psr_cond_unit.sv
// Processor status register fed by the ALU flag interface, with one shadow copy
// and a request/valid condition-code evaluator for the branch control FSM.
module psr_cond_unit #(
  parameter int FLAG_W = 5,
  parameter int OP_W   = 5,
  parameter int COND_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [OP_W-1:0]   OpCode,
  input  logic [FLAG_W-1:0] Flags,
  input  logic              psr_wr,
  input  logic [FLAG_W-1:0] psr_wdata,
  input  logic              psr_save,
  input  logic              psr_restore,
  input  logic              cond_req,
  input  logic [COND_W-1:0] cond_code,
  input  logic              cond_ready,
  output logic              cond_valid,
  output logic              cond_true,
  output logic              cond_busy,
  output logic [FLAG_W-1:0] psr
);

  localparam int C_BIT = 0;
  localparam int L_BIT = 1;
  localparam int F_BIT = 2;
  localparam int Z_BIT = 3;
  localparam int N_BIT = 4;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_CMP = OP_W'(2);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  typedef enum logic [COND_W-1:0] {
    CC_EQ, CC_NE, CC_CS, CC_CC, CC_HI, CC_LS, CC_GT, CC_LE,
    CC_FS, CC_FC, CC_LO, CC_HS, CC_LT, CC_GE, CC_UC, CC_NV
  } cond_e;

  logic [FLAG_W-1:0] psr_q, psr_d;
  logic [FLAG_W-1:0] shadow_q, shadow_d;
  logic [FLAG_W-1:0] lpsr_q;
  logic [COND_W-1:0] code_q;
  state_t            state_q;
  logic              valid_q, true_q, busy_q;

  function automatic logic cond_eval(input logic [FLAG_W-1:0] p, input logic [COND_W-1:0] c);
    logic res;
    case (cond_e'(c))
      CC_EQ: res = p[Z_BIT];
      CC_NE: res = !p[Z_BIT];
      CC_CS: res = p[C_BIT];
      CC_CC: res = !p[C_BIT];
      CC_HI: res = p[L_BIT];
      CC_LS: res = !p[L_BIT];
      CC_GT: res = p[N_BIT];
      CC_LE: res = !p[N_BIT];
      CC_FS: res = p[F_BIT];
      CC_FC: res = !p[F_BIT];
      CC_LO: res = !p[L_BIT] && !p[Z_BIT];
      CC_HS: res = p[L_BIT] || p[Z_BIT];
      CC_LT: res = !p[N_BIT] && !p[Z_BIT];
      CC_GE: res = p[N_BIT] || p[Z_BIT];
      CC_UC: res = 1'b1;
      CC_NV: res = 1'b0;
    endcase
    return res;
  endfunction

  // CMP leaves C and F undefined on the flag bus, so only the bits each opcode
  // owns are copied; everything else keeps its previous value.
  always_comb begin
    psr_d    = psr_q;
    shadow_d = shadow_q;
    if (alu_valid) begin
      case (OpCode)
        OP_ADD, OP_SUB: begin
          psr_d[C_BIT] = Flags[C_BIT];
          psr_d[F_BIT] = Flags[F_BIT];
        end
        OP_CMP: begin
          psr_d[L_BIT] = Flags[L_BIT];
          psr_d[Z_BIT] = Flags[Z_BIT];
          psr_d[N_BIT] = Flags[N_BIT];
        end
        default: ;
      endcase
    end
    if (psr_restore)  psr_d = shadow_q;
    else if (psr_wr)  psr_d = psr_wdata;
    if (psr_save) shadow_d = psr_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; save and restore together then swap psr and shadow cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psr_q    <= '0;
      shadow_q <= '0;
    end else begin
      psr_q    <= psr_d;
      shadow_q <= shadow_d;
    end
  end

  // The request latches the bypassed PSR, so later flag writes cannot disturb
  // a result that is already in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      lpsr_q  <= '0;
      valid_q <= 1'b0;
      true_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cond_req) begin
          code_q  <= cond_code;
          lpsr_q  <= psr_d;
          busy_q  <= 1'b1;
          state_q <= EVAL;
        end
        EVAL: begin
          true_q  <= cond_eval(lpsr_q, code_q);
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: if (cond_ready) begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign psr        = psr_q;
  assign cond_valid = valid_q;
  assign cond_true  = true_q;
  assign cond_busy  = busy_q;

endmodule

// File: tb/tb_psr_cond_unit.sv
// Scoreboard bench for psr_cond_unit: the driver keeps a flag-level reference
// model and queues expected responses; a monitor pops them as results appear.
module tb_psr_cond_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid;
  logic [4:0] OpCode;
  logic [4:0] Flags;
  logic       psr_wr;
  logic [4:0] psr_wdata;
  logic       psr_save;
  logic       psr_restore;
  logic       cond_req;
  logic [3:0] cond_code;
  logic       cond_ready;
  logic       cond_valid;
  logic       cond_true;
  logic       cond_busy;
  logic [4:0] psr;

  psr_cond_unit dut (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .OpCode(OpCode), .Flags(Flags),
    .psr_wr(psr_wr), .psr_wdata(psr_wdata), .psr_save(psr_save), .psr_restore(psr_restore),
    .cond_req(cond_req), .cond_code(cond_code), .cond_ready(cond_ready),
    .cond_valid(cond_valid), .cond_true(cond_true), .cond_busy(cond_busy), .psr(psr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic val;
    int   issue;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state, expressed in named flags rather than RTL signals.
  logic [4:0] psr_m;
  logic [4:0] shadow_m;
  bit         m_pending;
  int         m_issue;

  function automatic logic ref_cond(input logic [4:0] p, input int code);
    logic n = p[4], z = p[3], f = p[2], l = p[1], c = p[0];
    case (code)
      0: return z;         1: return !z;
      2: return c;         3: return !c;
      4: return l;         5: return !l;
      6: return n;         7: return !n;
      8: return f;         9: return !f;
      10: return !l && !z; 11: return l || z;
      12: return !n && !z; 13: return n || z;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_idle();
    alu_valid = 0; OpCode = 5'd3; Flags = 0; psr_wr = 0; psr_wdata = 0;
    psr_save = 0; psr_restore = 0; cond_req = 0; cond_code = 0; cond_ready = 1;
  endtask

  task automatic model_reset();
    psr_m = 0; shadow_m = 0; m_pending = 0; m_issue = 0;
    exp_q.delete();
  endtask

  // One clock: compare registered state against the model, advance the model
  // with this cycle's inputs, then move to just after the next rising edge.
  task automatic tick();
    logic [4:0] psr_n;
    @(negedge clk);
    check("psr", psr, psr_m);
    check("busy", cond_busy, m_pending);
    psr_n = psr_m;
    if (alu_valid) begin
      if (OpCode == 5'd0 || OpCode == 5'd1) begin
        psr_n[0] = Flags[0];
        psr_n[2] = Flags[2];
      end else if (OpCode == 5'd2) begin
        psr_n[1] = Flags[1];
        psr_n[3] = Flags[3];
        psr_n[4] = Flags[4];
      end
    end
    if (psr_wr) psr_n = psr_wdata;
    if (psr_restore) psr_n = shadow_m;
    if (psr_save) shadow_m = psr_m;
    if (m_pending) begin
      if (cyc - m_issue >= 2 && cond_ready) m_pending = 0;
    end else if (cond_req) begin
      m_pending = 1;
      m_issue   = cyc;
      exp_q.push_back('{val: ref_cond(psr_n, int'(cond_code)), issue: cyc});
    end
    psr_m = psr_n;
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks latency on the first valid cycle, stability while held,
  // and that valid falls right after acceptance.
  exp_t cur;
  bit   mon_prev_valid = 0;
  bit   mon_prev_acc   = 0;
  always @(negedge clk) begin
    if (reset) begin
      mon_prev_valid = 0;
      mon_prev_acc   = 0;
    end else begin
      if (mon_prev_acc) check("valid_drop", cond_valid, 1'b0);
      if (cond_valid && !mon_prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check("latency", cyc - cur.issue, 2);
          check("cond_true", cond_true, cur.val);
        end
      end else if (cond_valid) begin
        check("hold_true", cond_true, cur.val);
      end
      mon_prev_acc   = cond_valid && cond_ready;
      mon_prev_valid = cond_valid && !cond_ready;
    end
  end

  logic [4:0] sweep_vals [7];

  initial begin
    sweep_vals = '{5'b00000, 5'b01000, 5'b00010, 5'b10000, 5'b00001, 5'b00100, 5'b01010};
    set_idle();
    model_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_psr", psr, 0);
    check("rst_valid", cond_valid, 0);
    check("rst_true", cond_true, 0);
    check("rst_busy", cond_busy, 0);
    @(negedge clk) reset = 0;
    @(posedge clk);
    #1;

    // ADD then CMP masking, then XOR leaves PSR alone.
    alu_valid = 1; OpCode = 5'd0; Flags = 5'b00101; tick();
    OpCode = 5'd2; Flags = 5'b11x0x; tick();
    OpCode = 5'd5; Flags = 5'b10110; tick();
    set_idle(); tick();
    check("cmp_result", psr, 5'b11101);

    // Full condition sweep with ready held high.
    foreach (sweep_vals[v]) begin
      set_idle(); psr_wr = 1; psr_wdata = sweep_vals[v]; tick();
      for (int c = 0; c < 16; c++) begin
        set_idle(); cond_req = 1; cond_code = 4'(c); tick();
        set_idle(); repeat (2) tick();
      end
    end

    // Bypass: CMP sets Z in the same cycle as an EQ request.
    set_idle(); psr_wr = 1; psr_wdata = 5'b00000; tick();
    set_idle(); alu_valid = 1; OpCode = 5'd2; Flags = 5'b01000;
    cond_req = 1; cond_code = 4'd0; tick();
    set_idle(); repeat (3) tick();

    // Handshake hold: ready low while PSR churns and extra requests arrive.
    set_idle(); cond_req = 1; cond_code = 4'd13; tick();
    for (int i = 0; i < 5; i++) begin
      set_idle(); cond_ready = 0; psr_wr = 1; psr_wdata = 5'($urandom);
      cond_req = 1; cond_code = 4'($urandom); tick();
    end
    set_idle(); cond_req = 1; cond_code = 4'd14; tick();
    set_idle(); repeat (2) tick();

    // Save/restore priority and swap.
    set_idle(); psr_wr = 1; psr_wdata = 5'b10010; tick();
    set_idle(); psr_save = 1; tick();
    set_idle(); psr_wr = 1; psr_wdata = 5'b00001; psr_restore = 1; tick();
    set_idle(); psr_wr = 1; psr_wdata = 5'b00111; tick();
    set_idle(); psr_save = 1; psr_restore = 1; tick();
    set_idle(); psr_restore = 1; tick();
    set_idle(); tick();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      set_idle();
      alu_valid   = ($urandom_range(0, 3) != 0);
      OpCode      = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      Flags       = 5'($urandom);
      psr_wr      = ($urandom_range(0, 9) == 0);
      psr_wdata   = 5'($urandom);
      psr_save    = ($urandom_range(0, 9) == 0);
      psr_restore = ($urandom_range(0, 9) == 0);
      cond_req    = ($urandom_range(0, 1) != 0);
      cond_code   = 4'($urandom);
      cond_ready  = ($urandom_range(0, 1) != 0);
      tick();
    end
    set_idle(); repeat (4) tick();

    // Reset asserted in the middle of a held response.
    set_idle(); psr_wr = 1; psr_wdata = 5'b11111; tick();
    set_idle(); cond_req = 1; cond_code = 4'd14; tick();
    set_idle(); cond_ready = 0; repeat (3) tick();
    #2 reset = 1;
    #1;
    check("midrst_psr", psr, 0);
    check("midrst_valid", cond_valid, 0);
    check("midrst_busy", cond_busy, 0);
    model_reset();
    @(negedge clk) reset = 0;
    @(posedge clk);
    #1;
    set_idle(); cond_req = 1; cond_code = 4'd1; tick();
    set_idle(); repeat (4) tick();

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
